// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two requester byte streams plus the transmitter-side and status
// signals of uart_tx_arbiter; slave is the arbiter side, master the environment.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] tx_data;
    logic       tx_latch;
    logic       tx_busy;
    logic       lock;
    logic       owner;
    logic       busy;
    logic       err;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_data, tx_latch, lock, owner, busy, err
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_data, tx_latch, lock, owner, busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter feeding a single UART transmitter, with round-robin
// grant, optional per-message locking and a watchdog on the transmitter busy flag.
module uart_tx_arbiter #(
    parameter logic [7:0]  EOM_BYTE     = 8'h0A,
    parameter bit          LOCK_EN      = 1'b1,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd2000
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LATCH     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;
    localparam logic [1:0] WB_LAST   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_latch_q, tx_latch_d;
    logic        lock_q, lock_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic [1:0]  wb_cnt_q, wb_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;

    logic       elig0_s, elig1_s, grant0_s, grant1_s;
    logic       accept_ok_s, ready0_s, ready1_s, xfer_s, owner_valid_s;
    logic [7:0] xfer_data_s;

    // Eligibility and round-robin grant; ready is suppressed while rst is high
    always_comb begin
        elig0_s       = bus.req0_valid & (~lock_q | ~owner_q);
        elig1_s       = bus.req1_valid & (~lock_q | owner_q);
        grant1_s      = elig1_s & (~elig0_s | ~owner_q);
        grant0_s      = elig0_s & ~grant1_s;
        accept_ok_s   = (state_q == IDLE) & ~bus.tx_busy & ~rst;
        ready0_s      = accept_ok_s & grant0_s;
        ready1_s      = accept_ok_s & grant1_s;
        xfer_s        = ready0_s | ready1_s;
        xfer_data_s   = grant1_s ? bus.req1_data : bus.req0_data;
        owner_valid_s = owner_q ? bus.req1_valid : bus.req0_valid;
    end

    // Transfer FSM: accept, strobe the transmitter, then track its busy flag
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_latch_d = 1'b0;
        owner_d    = owner_q;
        err_d      = err_q;
        wb_cnt_d   = wb_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    state_d    = LATCH;
                    tx_data_d  = xfer_data_s;
                    tx_latch_d = 1'b1;
                    owner_d    = grant1_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LATCH: begin
                state_d  = WAIT_BUSY;
                wb_cnt_d = 2'd0;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (wb_cnt_q == WB_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wb_cnt_d = wb_cnt_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Message lock: set by a non-EOM byte, cleared by EOM or by an idle owner timing out
    always_comb begin
        lock_d   = lock_q;
        to_cnt_d = to_cnt_q;
        if (xfer_s) begin
            lock_d   = LOCK_EN ? (xfer_data_s != EOM_BYTE) : 1'b0;
            to_cnt_d = 16'd0;
        end else if (!lock_q) begin
            to_cnt_d = 16'd0;
        end else if ((state_q == IDLE) && !owner_valid_s) begin
            if (to_cnt_q >= (LOCK_TIMEOUT - 16'd1)) begin
                lock_d   = 1'b0;
                to_cnt_d = 16'd0;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // State registers; owner resets to 1 so the first contended grant goes to requester 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_latch_q <= 1'b0;
            lock_q     <= 1'b0;
            owner_q    <= 1'b1;
            err_q      <= 1'b0;
            wb_cnt_q   <= 2'd0;
            to_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_latch_q <= tx_latch_d;
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
            wb_cnt_q   <= wb_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_latch   = tx_latch_q;
    assign bus.lock       = lock_q;
    assign bus.owner      = owner_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: a LOCK_EN=0 instance (index 0) and a LOCK_EN=1, LOCK_TIMEOUT=16 instance (index 1).
module tb_uart_tx_arbiter;

    logic clk;
    logic rst;

    uart_tx_arbiter_if ni ();
    uart_tx_arbiter_if li ();

    uart_tx_arbiter #(.EOM_BYTE(8'h0A), .LOCK_EN(1'b0), .LOCK_TIMEOUT(16'd16)) u_nl (
        .clk(clk), .rst(rst), .bus(ni.slave)
    );
    uart_tx_arbiter #(.EOM_BYTE(8'h0A), .LOCK_EN(1'b1), .LOCK_TIMEOUT(16'd16)) u_lk (
        .clk(clk), .rst(rst), .bus(li.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic rst;
        logic v0;
        logic v1;
        logic busy;
        logic r0;
        logic r1;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    vec_t tbl[7];

    logic [7:0] s0_b[2][8];
    logic [7:0] s1_b[2][8];
    int         s0_n[2], s0_i[2], s1_n[2], s1_i[2];
    int         bcnt[2];
    logic       tx_dead[2], force_busy[2];

    logic       r0_s[2], r1_s[2], lat_s[2], lock_s[2], own_s[2], busy_s[2], err_s[2];
    logic [7:0] txd_s[2];
    logic       acc0[2], acc1[2];
    logic [7:0] acc0_b[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        exp_t e;
        e.d = d;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        ni.req0_valid = (s0_i[0] < s0_n[0]);
        ni.req0_data  = ni.req0_valid ? s0_b[0][s0_i[0][2:0]] : 8'h00;
        ni.req1_valid = (s1_i[0] < s1_n[0]);
        ni.req1_data  = ni.req1_valid ? s1_b[0][s1_i[0][2:0]] : 8'h00;
        ni.tx_busy    = (bcnt[0] > 0) || force_busy[0];
        li.req0_valid = (s0_i[1] < s0_n[1]);
        li.req0_data  = li.req0_valid ? s0_b[1][s0_i[1][2:0]] : 8'h00;
        li.req1_valid = (s1_i[1] < s1_n[1]);
        li.req1_data  = li.req1_valid ? s1_b[1][s1_i[1][2:0]] : 8'h00;
        li.tx_busy    = (bcnt[1] > 0) || force_busy[1];
    endtask

    task automatic snap();
        r0_s[0] = ni.req0_ready; r1_s[0] = ni.req1_ready; lat_s[0] = ni.tx_latch;
        lock_s[0] = ni.lock; own_s[0] = ni.owner; busy_s[0] = ni.busy; err_s[0] = ni.err;
        txd_s[0] = ni.tx_data;
        r0_s[1] = li.req0_ready; r1_s[1] = li.req1_ready; lat_s[1] = li.tx_latch;
        lock_s[1] = li.lock; own_s[1] = li.owner; busy_s[1] = li.busy; err_s[1] = li.err;
        txd_s[1] = li.tx_data;
        acc0[0] = ni.req0_valid && r0_s[0]; acc1[0] = ni.req1_valid && r1_s[0];
        acc0[1] = li.req0_valid && r0_s[1]; acc1[1] = li.req1_valid && r1_s[1];
        acc0_b[0] = ni.req0_data; acc0_b[1] = li.req0_data;
    endtask

    // One clock: sample mid-cycle, score latches, then advance sources and transmitter models
    task automatic step();
        exp_t e;
        @(negedge clk);
        snap();
        for (int d = 0; d < 2; d++) begin
            chk("both_ready", {31'd0, r0_s[d] & r1_s[d]}, 32'd0);
            if (lat_s[d]) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL latch_unexpected: dut%0d latched %0h, required no latch", d, txd_s[d]);
                end else begin
                    e = exp_q.pop_front();
                    chk("latch_dut", d, e.d);
                    chk("tx_data", {24'd0, txd_s[d]}, {24'd0, e.b});
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (acc0[d]) s0_i[d]++;
            if (acc1[d]) s1_i[d]++;
            if (lat_s[d] && !tx_dead[d]) bcnt[d] = 12;
            else if (bcnt[d] > 0) bcnt[d]--;
        end
        drive();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s0_n[d] = 0; s0_i[d] = 0; s1_n[d] = 0; s1_i[d] = 0;
            bcnt[d] = 0; tx_dead[d] = 1'b0; force_busy[d] = 1'b0;
        end
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_until_empty(input int max, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max) begin
            step();
            k++;
        end
        chk(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int   k, lat_k, idle_locked;
        logic pend, seen, released;

        // rst, v0, v1, tx_busy -> ready0, ready1 (owner=1, unlocked, IDLE)
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        apply_reset();
        chk("rst_lock", li.lock, 32'd0);
        chk("rst_owner", li.owner, 32'd1);
        chk("rst_busy", li.busy, 32'd0);
        chk("rst_err", li.err, 32'd0);
        chk("rst_tx_data", {24'd0, li.tx_data}, 32'd0);
        chk("rst_tx_latch", li.tx_latch, 32'd0);

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst;
            ni.req0_valid = tbl[i].v0;
            ni.req1_valid = tbl[i].v1;
            ni.req0_data  = 8'h10;
            ni.req1_data  = 8'h20;
            ni.tx_busy    = tbl[i].busy;
            #1;
            chk("tbl_ready0", ni.req0_ready, {31'd0, tbl[i].r0});
            chk("tbl_ready1", ni.req1_ready, {31'd0, tbl[i].r1});
            rst = 1'b0;
            drive();
            @(posedge clk);
            #1;
        end
        chk("tbl_no_transfer", ni.busy, 32'd0);

        // Pure round-robin with both requesters always offering
        apply_reset();
        s0_b[0][0] = 8'h41; s0_b[0][1] = 8'h41; s0_n[0] = 2;
        s1_b[0][0] = 8'h42; s1_b[0][1] = 8'h42; s1_n[0] = 2;
        push(0, 8'h41); push(0, 8'h42); push(0, 8'h41); push(0, 8'h42);
        drive();
        run_until_empty(200, "rr_order_done");
        repeat (20) step();

        // Locked message 48,49,0A holds off requester 1 until EOM
        apply_reset();
        s0_b[1][0] = 8'h48; s0_b[1][1] = 8'h49; s0_b[1][2] = 8'h0A; s0_n[1] = 3;
        s1_b[1][0] = 8'h5A; s1_n[1] = 1;
        push(1, 8'h48); push(1, 8'h49); push(1, 8'h0A); push(1, 8'h5A);
        drive();
        pend = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            step();
            k++;
            if (pend) begin
                chk("eom_lock_fall", lock_s[1], 32'd0);
                pend = 1'b0;
            end
            if (acc0[1] && acc0_b[1] == 8'h0A) begin
                chk("eom_lock_held", lock_s[1], 32'd1);
                pend = 1'b1;
            end
        end
        chk("eom_done", exp_q.size(), 32'd0);
        exp_q.delete();

        // Owner goes silent: lock holds 16 idle cycles then requester 1 is granted
        apply_reset();
        s0_b[1][0] = 8'h48; s0_n[1] = 1;
        s1_b[1][0] = 8'h5A; s1_n[1] = 1;
        push(1, 8'h48); push(1, 8'h5A);
        drive();
        idle_locked = 0; seen = 1'b0; released = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            step();
            k++;
            if (!released) begin
                if (lock_s[1]) seen = 1'b1;
                if (lock_s[1] && !busy_s[1]) idle_locked++;
                if (seen && !lock_s[1]) begin
                    released = 1'b1;
                    chk("timeout_grant_req1", r1_s[1], 32'd1);
                end
            end
        end
        chk("idle_locked_cycles", idle_locked, 32'd16);
        chk("timeout_done", exp_q.size(), 32'd0);
        exp_q.delete();

        // Transmitter never raises busy: err after four WAIT_BUSY cycles, next byte still taken
        apply_reset();
        tx_dead[1] = 1'b1;
        s0_b[1][0] = 8'h0A; s0_b[1][1] = 8'h0D; s0_n[1] = 2;
        push(1, 8'h0A); push(1, 8'h0D);
        drive();
        lat_k = -1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            if (lat_s[1] && lat_k < 0) lat_k = k;
            if (lat_k >= 0 && k == lat_k + 4) chk("err_not_yet", err_s[1], 32'd0);
            if (lat_k >= 0 && k == lat_k + 5) begin
                chk("err_set", err_s[1], 32'd1);
                chk("idle_after_err", busy_s[1], 32'd0);
            end
            k++;
        end
        chk("err_next_done", exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (8) step();
        chk("err_sticky", err_s[1], 32'd1);

        // Reset in WAIT_DONE with lock held, then contended request goes to requester 0
        apply_reset();
        s0_b[1][0] = 8'h48; s0_n[1] = 1;
        push(1, 8'h48);
        drive();
        run_until_empty(50, "pre_rst_latch");
        repeat (2) step();
        chk("pre_rst_lock", lock_s[1], 32'd1);
        chk("pre_rst_busy", busy_s[1], 32'd1);
        rst = 1'b1;
        bcnt[1] = 0;
        s0_b[1][0] = 8'h41; s0_i[1] = 0; s0_n[1] = 1;
        s1_b[1][0] = 8'h42; s1_i[1] = 0; s1_n[1] = 1;
        drive();
        #1;
        chk("mid_rst_lock", li.lock, 32'd0);
        chk("mid_rst_owner", li.owner, 32'd1);
        chk("mid_rst_busy", li.busy, 32'd0);
        chk("mid_rst_err", li.err, 32'd0);
        chk("mid_rst_tx_data", {24'd0, li.tx_data}, 32'd0);
        chk("mid_rst_tx_latch", li.tx_latch, 32'd0);
        chk("mid_rst_ready0", li.req0_ready, 32'd0);
        chk("mid_rst_ready1", li.req1_ready, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1, 8'h41); push(1, 8'h42);
        run_until_empty(300, "post_rst_order");

        // External busy blocks acceptance until it falls
        apply_reset();
        force_busy[1] = 1'b1;
        s0_b[1][0] = 8'h0A; s0_n[1] = 1;
        push(1, 8'h0A);
        drive();
        repeat (5) begin
            step();
            chk("busy_hold_ready0", r0_s[1], 32'd0);
        end
        force_busy[1] = 1'b0;
        drive();
        #1;
        chk("ready_on_busy_drop", li.req0_ready, 32'd1);
        run_until_empty(50, "busy_drop_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
